// File: rtl/data_mem_arbiter.sv
// Arbiter sharing one single-port synchronous data RAM between the CPU
// load/store port and a secondary peripheral master. The CPU wins by
// default; a starvation counter forces a peripheral grant after MAX_WAIT
// consecutive denied cycles. cpu_stall freezes the single-cycle core while
// its access is pending or its load data is still returning.
module data_mem_arbiter #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              per_valid,
  input  logic              per_we,
  input  logic [ADDR_W-1:0] per_addr,
  input  logic [DATA_W-1:0] per_wdata,
  output logic              per_ready,
  output logic              per_rvalid,
  output logic [DATA_W-1:0] per_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CPU_RD = 2'd1,
    ST_PER_RD = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [CNT_W-1:0] r_starve_cnt;
  logic             w_cpu_live;
  logic             w_force;
  logic             w_per_gnt;
  logic             w_cpu_gnt;

  // Grant decision; a CPU load in its return cycle is already served.
  // Everything is gated by rst so outputs sit at reset values while held.
  always_comb begin
    w_cpu_live = rst && cpu_req && (r_state != ST_CPU_RD);
    w_force    = (r_starve_cnt == CNT_W'(MAX_WAIT));
    w_per_gnt  = rst && per_valid && (w_force || !w_cpu_live);
    w_cpu_gnt  = w_cpu_live && !w_per_gnt;
  end

  // State register: tracks which master has read data returning.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next state depends only on this cycle's grant, so returns overlap new grants.
  always_comb begin
    w_next_state = ST_IDLE;
    if (w_cpu_gnt && !cpu_we) begin
      w_next_state = ST_CPU_RD;
    end else if (w_per_gnt && !per_we) begin
      w_next_state = ST_PER_RD;
    end
  end

  // Output decode: RAM mux, handshakes, stall and read-data steering.
  always_comb begin
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    per_ready  = w_per_gnt;
    cpu_stall  = w_cpu_live && !(w_cpu_gnt && cpu_we);
    per_rvalid = 1'b0;
    per_rdata  = '0;
    cpu_rdata  = '0;
    if (w_per_gnt) begin
      mem_en    = 1'b1;
      mem_we    = per_we;
      mem_addr  = per_addr;
      mem_wdata = per_wdata;
    end else if (w_cpu_gnt) begin
      mem_en    = 1'b1;
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end
    if (rst && (r_state == ST_PER_RD)) begin
      per_rvalid = 1'b1;
      per_rdata  = mem_rdata;
    end
    if (rst && (r_state == ST_CPU_RD)) begin
      cpu_rdata = mem_rdata;
    end
  end

  // Starvation counter: consecutive cycles the peripheral waited unserved.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_starve_cnt <= '0;
    end else if (!per_valid || per_ready) begin
      r_starve_cnt <= '0;
    end else if (r_starve_cnt != CNT_W'(MAX_WAIT)) begin
      r_starve_cnt <= r_starve_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a behavioural synchronous RAM.
module tb_data_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        per_valid;
  logic        per_we;
  logic [31:0] per_addr;
  logic [31:0] per_wdata;
  logic        per_ready;
  logic        per_rvalid;
  logic [31:0] per_rdata;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int total;
  int bad;

  logic [31:0] ram [0:255];

  data_mem_arbiter #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .MAX_WAIT(4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_stall (cpu_stall),
    .per_valid (per_valid),
    .per_we    (per_we),
    .per_addr  (per_addr),
    .per_wdata (per_wdata),
    .per_ready (per_ready),
    .per_rvalid(per_rvalid),
    .per_rdata (per_rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word-addressed synchronous RAM, read data valid the cycle after issue.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr[9:2]] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr[9:2]];
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cpu_req   = 1'b0;
    cpu_we    = 1'b0;
    cpu_addr  = 32'h0;
    cpu_wdata = 32'h0;
    per_valid = 1'b0;
    per_we    = 1'b0;
    per_addr  = 32'h0;
    per_wdata = 32'h0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'd12;
    per_valid = 1'b1; per_we = 1'b0; per_addr = 32'h40;
    step();
    @(negedge clk);
    total++;
    if ({mem_en, mem_we, cpu_stall, per_ready, per_rvalid} !== 5'b0) begin
      $display("FAIL reset_ctrl got=%b exp=00000", {mem_en, mem_we, cpu_stall, per_ready, per_rvalid});
      bad++;
    end
    total++;
    if (cpu_rdata !== 32'h0) begin
      $display("FAIL reset_cpu_rdata got=%h exp=0", cpu_rdata); bad++;
    end
    total++;
    if (per_rdata !== 32'h0) begin
      $display("FAIL reset_per_rdata got=%h exp=0", per_rdata); bad++;
    end
    idle_inputs();
    rst = 1'b1;
    step();
  endtask

  task automatic test_cpu_store();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'd12; cpu_wdata = 32'd16;
    @(negedge clk);
    total++;
    if ({mem_en, mem_we, cpu_stall} !== 3'b110) begin
      $display("FAIL store_ctrl got=%b exp=110", {mem_en, mem_we, cpu_stall}); bad++;
    end
    total++;
    if (mem_addr !== 32'd12 || mem_wdata !== 32'd16) begin
      $display("FAIL store_bus got=%h/%h exp=0000000c/00000010", mem_addr, mem_wdata); bad++;
    end
    step();
    idle_inputs();
    total++;
    if (ram[3] !== 32'd16) begin
      $display("FAIL store_ram got=%h exp=00000010", ram[3]); bad++;
    end
    step();
  endtask

  task automatic test_cpu_load();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'd12; cpu_wdata = 32'd4;
    step();
    cpu_we = 1'b0; cpu_wdata = 32'h0;
    @(negedge clk);
    total++;
    if ({cpu_stall, mem_en, mem_we} !== 3'b110 || mem_addr !== 32'd12) begin
      $display("FAIL load_issue got=%b addr=%h exp=110 addr=0000000c", {cpu_stall, mem_en, mem_we}, mem_addr);
      bad++;
    end
    step();
    @(negedge clk);
    total++;
    if (cpu_rdata !== 32'd4) begin
      $display("FAIL load_data got=%h exp=00000004", cpu_rdata); bad++;
    end
    total++;
    if ({cpu_stall, mem_en} !== 2'b00) begin
      $display("FAIL load_return got=%b exp=00", {cpu_stall, mem_en}); bad++;
    end
    step();
    idle_inputs();
    @(negedge clk);
    total++;
    if (cpu_rdata !== 32'h0) begin
      $display("FAIL load_rdata_idle got=%h exp=0", cpu_rdata); bad++;
    end
    step();
  endtask

  task automatic test_per_read();
    per_valid = 1'b1; per_we = 1'b1; per_addr = 32'h40; per_wdata = 32'hCAFE;
    @(negedge clk);
    total++;
    if ({per_ready, mem_en, mem_we} !== 3'b111) begin
      $display("FAIL per_write got=%b exp=111", {per_ready, mem_en, mem_we}); bad++;
    end
    step();
    idle_inputs();
    @(negedge clk);
    total++;
    if (per_rvalid !== 1'b0) begin
      $display("FAIL per_write_no_beat got=%b exp=0", per_rvalid); bad++;
    end
    step();
    per_valid = 1'b1; per_we = 1'b0; per_addr = 32'h40;
    @(negedge clk);
    total++;
    if ({per_ready, mem_en, mem_we, cpu_stall} !== 4'b1100 || mem_addr !== 32'h40) begin
      $display("FAIL per_rd_issue got=%b addr=%h exp=1100 addr=00000040", {per_ready, mem_en, mem_we, cpu_stall}, mem_addr);
      bad++;
    end
    step();
    idle_inputs();
    @(negedge clk);
    total++;
    if (per_rvalid !== 1'b1 || per_rdata !== 32'hCAFE) begin
      $display("FAIL per_rd_data got=%b/%h exp=1/0000cafe", per_rvalid, per_rdata); bad++;
    end
    step();
    @(negedge clk);
    total++;
    if (per_rvalid !== 1'b0 || per_rdata !== 32'h0) begin
      $display("FAIL per_rd_end got=%b/%h exp=0/0", per_rvalid, per_rdata); bad++;
    end
    step();
  endtask

  task automatic test_starvation();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h80; cpu_wdata = 32'h11;
    per_valid = 1'b1; per_we = 1'b1; per_addr = 32'h84; per_wdata = 32'h55;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      total++;
      if ({per_ready, cpu_stall, mem_we} !== 3'b001 || mem_addr !== 32'h80) begin
        $display("FAIL starve_deny%0d got=%b addr=%h exp=001 addr=00000080", c, {per_ready, cpu_stall, mem_we}, mem_addr);
        bad++;
      end
      step();
    end
    @(negedge clk);
    total++;
    if ({per_ready, cpu_stall, mem_we} !== 3'b111) begin
      $display("FAIL starve_force got=%b exp=111", {per_ready, cpu_stall, mem_we}); bad++;
    end
    total++;
    if (mem_addr !== 32'h84 || mem_wdata !== 32'h55) begin
      $display("FAIL starve_force_bus got=%h/%h exp=00000084/00000055", mem_addr, mem_wdata); bad++;
    end
    step();
    @(negedge clk);
    total++;
    if ({per_ready, cpu_stall} !== 2'b00 || mem_addr !== 32'h80) begin
      $display("FAIL starve_cleared got=%b addr=%h exp=00 addr=00000080", {per_ready, cpu_stall}, mem_addr);
      bad++;
    end
    step();
    idle_inputs();
    total++;
    if (ram[33] !== 32'h55 || ram[32] !== 32'h11) begin
      $display("FAIL starve_ram got=%h/%h exp=00000055/00000011", ram[33], ram[32]); bad++;
    end
    step();
  endtask

  task automatic test_back_to_back();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'd12; cpu_wdata = 32'd4;
    step();
    cpu_we = 1'b0; cpu_wdata = 32'h0;
    step();
    per_valid = 1'b1; per_we = 1'b1; per_addr = 32'h44; per_wdata = 32'd7;
    @(negedge clk);
    total++;
    if (cpu_rdata !== 32'd4 || cpu_stall !== 1'b0) begin
      $display("FAIL b2b_cpu got=%h/%b exp=00000004/0", cpu_rdata, cpu_stall); bad++;
    end
    total++;
    if ({per_ready, mem_en, mem_we} !== 3'b111 || mem_addr !== 32'h44 || mem_wdata !== 32'd7) begin
      $display("FAIL b2b_per got=%b %h/%h exp=111 00000044/00000007", {per_ready, mem_en, mem_we}, mem_addr, mem_wdata);
      bad++;
    end
    step();
    idle_inputs();
    @(negedge clk);
    total++;
    if (ram[17] !== 32'd7 || cpu_rdata !== 32'h0 || per_rvalid !== 1'b0) begin
      $display("FAIL b2b_after got=%h/%h/%b exp=00000007/0/0", ram[17], cpu_rdata, per_rvalid); bad++;
    end
    step();
  endtask

  task automatic test_reset_mid_read();
    per_valid = 1'b1; per_we = 1'b0; per_addr = 32'h40;
    @(negedge clk);
    total++;
    if (per_ready !== 1'b1) begin
      $display("FAIL rmid_issue got=%b exp=1", per_ready); bad++;
    end
    step();
    idle_inputs();
    rst = 1'b0;
    @(negedge clk);
    total++;
    if ({per_rvalid, mem_en, cpu_stall} !== 3'b000 || per_rdata !== 32'h0) begin
      $display("FAIL rmid_held got=%b/%h exp=000/0", {per_rvalid, mem_en, cpu_stall}, per_rdata); bad++;
    end
    step();
    rst = 1'b1;
    @(negedge clk);
    total++;
    if ({per_rvalid, per_ready, mem_en} !== 3'b000 || per_rdata !== 32'h0 || cpu_rdata !== 32'h0) begin
      $display("FAIL rmid_idle got=%b/%h/%h exp=000/0/0", {per_rvalid, per_ready, mem_en}, per_rdata, cpu_rdata);
      bad++;
    end
    step();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_cpu_store();
    test_cpu_load();
    test_per_read();
    test_starvation();
    test_back_to_back();
    test_reset_mid_read();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
